uart_tx_arbiter: RTL and testbench

//  Round-robin scheduler sharing one uart_transmitter between NUM_REQ requesters.

---
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_TX_ARB_GAP_EN to insert GAP_CYCLES idle cycles after every completed frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int BUSY_TIMEOUT = 8,
    parameter int GAP_CYCLES   = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_en,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         active,
    output logic [NUM_REQ-1:0]           frame_done,
    output logic                         start_err
);
    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CMAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

`ifdef UART_TX_ARB_GAP_EN
    localparam state_t DONE_NXT = (GAP_CYCLES > 0) ? GAP : IDLE;
`else
    localparam state_t DONE_NXT = IDLE;
`endif

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] pick;
    logic           found;
    logic [CW-1:0]  cnt;
    logic           cnt_clr;

    // First valid requester strictly after the last served one, wrapping.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick  = IDW'((int'(rr_ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        tx_en     = 1'b0;
        start_err = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid && !tx_busy) state_nxt = GRANT;
            end
            GRANT: begin
                req_ready[grant_id] = 1'b1;
                state_nxt = req_valid[grant_id] ? LAUNCH : IDLE;
            end
            LAUNCH: begin
                tx_en     = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // tx_done wins over both busy and timeout when they coincide.
                if (tx_done) begin
                    state_nxt = DONE_NXT;
                end else if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (int'(cnt) >= BUSY_TIMEOUT) begin
                    start_err = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) state_nxt = DONE_NXT;
            end
            GAP: begin
                if (int'(cnt) >= GAP_CYCLES - 1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter reads 0 during LAUNCH and during the first GAP cycle.
    assign cnt_clr = (state == GRANT) || (state != GAP && state_nxt == GAP);
    assign active  = (state != IDLE);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            grant_id   <= '0;
            rr_ptr     <= IDW'(NUM_REQ - 1);
            tx_data    <= '0;
            cnt        <= '0;
            frame_done <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= '0;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt != {CW{1'b1}}) begin
                cnt <= cnt + CW'(1);
            end
            if (state == IDLE && state_nxt == GRANT) grant_id <= pick;
            if (state == GRANT && req_valid[grant_id]) begin
                tx_data <= req_data[int'(grant_id)*DATA_BITS +: DATA_BITS];
                rr_ptr  <= grant_id;
            end
            if ((state == WAIT_BUSY || state == WAIT_DONE) && tx_done) frame_done[grant_id] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter stub plus a round-robin reference model.
module tb_uart_tx_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        active;
    logic [3:0]  frame_done;
    logic        start_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit stub_on   = 1'b0;
    bit stub_busy = 1'b0;

`ifdef UART_TX_ARB_GAP_EN
    localparam int GAP_EXP = 17;
`else
    localparam int GAP_EXP = 1;
`endif

    uart_tx_arbiter dut (
        .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .grant_id(grant_id), .active(active),
        .frame_done(frame_done), .start_err(start_err)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Transmitter stub: busy a few cycles after tx_en, then a one-cycle tx_done.
    initial begin
        int d1, d2;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge PCLK);
            if (stub_on && tx_en) begin
                stub_busy = 1'b1;
                d1 = $urandom_range(1, 3);
                d2 = $urandom_range(1, 5);
                repeat (d1) @(posedge PCLK);
                #1 tx_busy = 1'b1;
                repeat (d2) @(posedge PCLK);
                #1 tx_done = 1'b1; tx_busy = 1'b0;
                @(posedge PCLK);
                #1 tx_done = 1'b0;
                stub_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        req_valid = '0;
        for (int i = 0; i < 200 && stub_busy; i++) @(posedge PCLK);
        total++;
        if (stub_busy) begin
            bad++;
            $display("FAIL stub_drain: stub busy=%0b required 0", stub_busy);
        end
        stub_on = 1'b0;
        #1;
        PRESET  = 1'b1;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
    endtask

    task automatic test_reset;
        PRESET    = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        @(negedge PCLK);
        @(negedge PCLK);
        total++;
        if ({req_ready, tx_en, frame_done, start_err, active} !== 11'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 0", {req_ready, tx_en, frame_done, start_err, active});
        end
        total++;
        if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_data: tx_data=%h grant_id=%0d required 00/0", tx_data, grant_id);
        end
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle_cycle: req_ready=%b required 0000", req_ready);
        end
        @(negedge PCLK);
        total++;
        if (req_ready !== 4'b0001 || active !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_grant: req_ready=%b active=%b required 0001/1", req_ready, active);
        end
    endtask

    task automatic test_single_byte;
        int t_set, t_rdy, t_en, t_done, t_fd;
        logic [3:0] rdy_v, fd_v;
        logic [7:0] dat_v;
        logic act_fd;
        t_rdy = -1; t_en = -1; t_done = -1; t_fd = -1;
        do_reset;
        stub_on   = 1'b1;
        req_data  = 32'h00550000;
        req_valid = 4'b0100;
        t_set     = cyc;
        for (int c = 0; c < 300 && t_fd < 0; c++) begin
            @(negedge PCLK);
            if (req_ready !== 4'b0000 && t_rdy < 0) begin t_rdy = cyc; rdy_v = req_ready; end
            if (tx_en === 1'b1 && t_en < 0) begin t_en = cyc; dat_v = tx_data; end
            if (tx_done === 1'b1 && t_done < 0) t_done = cyc;
            if (frame_done !== 4'b0000) begin t_fd = cyc; fd_v = frame_done; act_fd = active; end
            @(posedge PCLK);
            #1;
            if (t_rdy >= 0) req_valid = 4'b0000;
        end
        total++;
        if (t_rdy != t_set + 1 || rdy_v !== 4'b0100) begin
            bad++;
            $display("FAIL single_ready: at +%0d value %b required +1 0100", t_rdy - t_set, rdy_v);
        end
        total++;
        if (t_rdy < 0 || t_en != t_rdy + 1 || dat_v !== 8'h55) begin
            bad++;
            $display("FAIL single_launch: tx_en at +%0d data %h required +1 55", t_en - t_rdy, dat_v);
        end
        total++;
        if (t_done < 0 || t_fd != t_done + 1 || fd_v !== 4'b0100) begin
            bad++;
            $display("FAIL single_frame_done: at done+%0d value %b required +1 0100", t_fd - t_done, fd_v);
        end
        total++;
        if (t_fd < 0 || act_fd !== (GAP_EXP > 1)) begin
            bad++;
            $display("FAIL single_active: active=%b at frame_done required %b", act_fd, GAP_EXP > 1);
        end
    endtask

    task automatic test_round_robin;
        int prev, exp, nfd;
        int gq[$];
        int fdcnt[4];
        fdcnt = '{0, 0, 0, 0};
        prev = 3; nfd = 0;
        do_reset;
        stub_on   = 1'b1;
        req_data  = 32'h44332211;
        req_valid = 4'hF;
        for (int c = 0; c < 2000 && nfd < 5; c++) begin
            @(negedge PCLK);
            if (req_ready !== 4'b0000) begin
                exp = (prev + 1) % 4;
                total++;
                if (req_ready !== 4'(1 << exp)) begin
                    bad++;
                    $display("FAIL rr_grant: req_ready=%b required %b", req_ready, 4'(1 << exp));
                end
                prev = exp;
                gq.push_back(exp);
            end
            if (tx_en === 1'b1) begin
                total++;
                if (gq.size() == 0 || tx_data !== 8'(8'h11 * (gq[$] + 1))) begin
                    bad++;
                    $display("FAIL rr_data: tx_data=%h", tx_data);
                end
            end
            if (frame_done !== 4'b0000) begin
                total++;
                if (gq.size() == 0 || frame_done !== 4'(1 << gq[0])) begin
                    bad++;
                    $display("FAIL rr_done: frame_done=%b", frame_done);
                end else begin
                    fdcnt[gq[0]]++;
                end
                if (gq.size() > 0) void'(gq.pop_front());
                nfd++;
            end
            @(posedge PCLK);
            #1;
        end
        req_valid = 4'b0000;
        total++;
        if (nfd != 5 || fdcnt[0] != 2 || fdcnt[1] != 1 || fdcnt[2] != 1 || fdcnt[3] != 1) begin
            bad++;
            $display("FAIL rr_rotation: frames=%0d counts=%0d,%0d,%0d,%0d required 5 2,1,1,1",
                     nfd, fdcnt[0], fdcnt[1], fdcnt[2], fdcnt[3]);
        end
    endtask

    task automatic test_timeout;
        int t_en, t_err, nfd, nerr, ngrant;
        logic [3:0] g2;
        t_en = -1; t_err = -1; nfd = 0; nerr = 0; ngrant = 0;
        do_reset;
        req_data  = 32'h0000BBAA;
        req_valid = 4'b0011;
        for (int c = 0; c < 100 && ngrant < 2; c++) begin
            @(negedge PCLK);
            if (req_ready !== 4'b0000) begin
                ngrant++;
                if (ngrant == 2) g2 = req_ready;
            end
            if (tx_en === 1'b1 && t_en < 0) t_en = cyc;
            if (start_err === 1'b1) begin nerr++; if (t_err < 0) t_err = cyc; end
            if (frame_done !== 4'b0000) nfd++;
            @(posedge PCLK);
            #1;
            if (ngrant == 1) req_valid[0] = 1'b0;
        end
        total++;
        if (t_en < 0 || t_err != t_en + 8 || nerr != 1) begin
            bad++;
            $display("FAIL timeout_err: start_err at tx_en+%0d pulses=%0d required +8 1", t_err - t_en, nerr);
        end
        total++;
        if (nfd != 0) begin
            bad++;
            $display("FAIL timeout_no_done: frame_done pulses=%0d required 0", nfd);
        end
        total++;
        if (ngrant != 2 || g2 !== 4'b0010) begin
            bad++;
            $display("FAIL timeout_next_grant: req_ready=%b required 0010", g2);
        end
    endtask

    task automatic test_valid_drop;
        int got, nen;
        logic [3:0] r1, r2;
        logic act2;
        got = -1; nen = 0; r2 = 4'b0000;
        do_reset;
        req_data  = 32'h00003300;
        req_valid = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            @(negedge PCLK);
            if (req_ready !== 4'b0000) begin
                r1 = req_ready;
                req_valid = 4'b0000;
                got = c;
                break;
            end
            @(posedge PCLK);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            if (tx_en === 1'b1) nen++;
            if (i == 0) act2 = active;
        end
        total++;
        if (got < 0 || r1 !== 4'b0010) begin
            bad++;
            $display("FAIL drop_grant: req_ready=%b required 0010", r1);
        end
        total++;
        if (nen != 0 || act2 !== 1'b0) begin
            bad++;
            $display("FAIL drop_abort: tx_en pulses=%0d active=%b required 0/0", nen, act2);
        end
        @(posedge PCLK);
        #1 req_valid = 4'b1011;
        for (int c = 0; c < 6 && r2 === 4'b0000; c++) begin
            @(negedge PCLK);
            r2 = req_ready;
        end
        total++;
        if (r2 !== 4'b0001) begin
            bad++;
            $display("FAIL drop_pointer: req_ready=%b required 0001", r2);
        end
    endtask

    task automatic test_busy_block;
        int nr, t, t_r;
        logic [3:0] rv;
        nr = 0; t_r = -1;
        do_reset;
        tx_busy   = 1'b1;
        req_valid = 4'b0100;
        repeat (6) begin
            @(negedge PCLK);
            if (req_ready !== 4'b0000) nr++;
        end
        total++;
        if (nr != 0) begin
            bad++;
            $display("FAIL busy_block: %0d grants while busy required 0", nr);
        end
        @(posedge PCLK);
        #1 tx_busy = 1'b0;
        t = cyc;
        for (int c = 0; c < 5 && t_r < 0; c++) begin
            @(negedge PCLK);
            if (req_ready !== 4'b0000) begin t_r = cyc; rv = req_ready; end
        end
        total++;
        if (t_r != t + 1 || rv !== 4'b0100) begin
            bad++;
            $display("FAIL busy_release: grant at +%0d value %b required +1 0100", t_r - t, rv);
        end
    endtask

    task automatic test_back_to_back;
        int t_fd, t_r2, nr;
        logic [3:0] r2;
        t_fd = -1; t_r2 = -1; nr = 0;
        do_reset;
        stub_on   = 1'b1;
        req_data  = 32'h00005599;
        req_valid = 4'b0001;
        for (int c = 0; c < 500 && t_r2 < 0; c++) begin
            @(negedge PCLK);
            if (frame_done !== 4'b0000 && t_fd < 0) t_fd = cyc;
            if (req_ready !== 4'b0000) begin
                nr++;
                if (nr == 2) begin t_r2 = cyc; r2 = req_ready; end
            end
            @(posedge PCLK);
            #1;
            if (nr == 1) req_valid = 4'b0010;
            if (nr >= 2) req_valid = 4'b0000;
        end
        total++;
        if (t_r2 < 0 || r2 !== 4'b0010) begin
            bad++;
            $display("FAIL b2b_grant: req_ready=%b required 0010", r2);
        end
        total++;
        if (t_fd < 0 || t_r2 - t_fd != GAP_EXP) begin
            bad++;
            $display("FAIL b2b_spacing: second grant at frame_done+%0d required +%0d", t_r2 - t_fd, GAP_EXP);
        end
    endtask

    task automatic test_random_traffic;
        int last, exp, served, r_cyc, rid;
        bit done_prev, rearm;
        int fdq[$];
        logic [7:0] acc_byte;
        last = 3; served = 0; r_cyc = -10; done_prev = 1'b0; acc_byte = 8'h00; rid = 0;
        do_reset;
        stub_on   = 1'b1;
        req_data  = $urandom;
        req_valid = 4'($urandom_range(1, 15));
        for (int c = 0; c < 3000 && !(served >= 12 && fdq.size() == 0); c++) begin
            @(negedge PCLK);
            rearm = 1'b0;
            if (done_prev) begin
                total++;
                if (fdq.size() == 0 || frame_done !== 4'(1 << fdq[0])) begin
                    bad++;
                    $display("FAIL rand_done: frame_done=%b", frame_done);
                end
                if (fdq.size() > 0) void'(fdq.pop_front());
            end else if (frame_done !== 4'b0000) begin
                total++;
                bad++;
                $display("FAIL rand_spurious_done: frame_done=%b required 0000", frame_done);
            end
            done_prev = (tx_done === 1'b1);
            if (req_ready !== 4'b0000) begin
                exp = -1;
                for (int k = 1; k <= 4; k++)
                    if (exp < 0 && req_valid[(last + k) % 4]) exp = (last + k) % 4;
                total++;
                if (exp < 0 || req_ready !== 4'(1 << exp)) begin
                    bad++;
                    $display("FAIL rand_grant: req_ready=%b valid=%b last=%0d", req_ready, req_valid, last);
                end
                if (exp >= 0) begin
                    last     = exp;
                    acc_byte = req_data[exp*8 +: 8];
                    fdq.push_back(exp);
                    served++;
                    r_cyc = cyc;
                    rearm = 1'b1;
                    rid   = exp;
                end
            end
            if (tx_en === 1'b1) begin
                total++;
                if (cyc != r_cyc + 1 || tx_data !== acc_byte) begin
                    bad++;
                    $display("FAIL rand_launch: tx_data=%h at ready+%0d required %h at +1", tx_data, cyc - r_cyc, acc_byte);
                end
            end
            @(posedge PCLK);
            #1;
            if (rearm) begin
                req_valid[rid] = (served < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
                req_data[rid*8 +: 8] = 8'($urandom);
                for (int i = 0; i < 4; i++) begin
                    if (!req_valid[i] && i != rid && served < 12 && $urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[i*8 +: 8] = 8'($urandom);
                    end
                end
                if (req_valid == 4'b0000 && served < 12) req_valid[$urandom_range(0, 3)] = 1'b1;
            end
        end
        req_valid = 4'b0000;
        total++;
        if (served < 12 || fdq.size() != 0) begin
            bad++;
            $display("FAIL rand_progress: served=%0d outstanding=%0d required >=12 0", served, fdq.size());
        end
    endtask

    initial begin
        PRESET    = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        test_reset;
        test_single_byte;
        test_round_robin;
        test_timeout;
        test_valid_drop;
        test_busy_block;
        test_back_to_back;
        test_random_traffic;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
